pc_unit: RTL and testbench

- Parametrised next-generation program counter for the pipelined RV core's fetch stage.
- Computes the next PC from sequential increment or branch/jump redirect, and honours pipeline stall and stage flush.
- Adds a debugger run-control state machine (halt, resume, single-step, PC write while halted) and a PC-update counter.
- Sits between the hazard/branch unit, the external debugger interface and the instruction memory address port.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 90 +++++++++
 tb/tb_pc_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-PC control and observation bundle between core/debugger and pc_unit
interface pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             reset_stages;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic             halt_req;
    logic             resume_req;
    logic             step_req;
    logic             dbg_pc_we;
    logic [XLEN-1:0]  dbg_pc_wdata;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus;
    logic             halted;
    logic             step_done;
    logic [CNT_W-1:0] upd_count;
    logic             misalign_flag;

    modport master (
        output stall, reset_stages, redirect_valid, redirect_target,
               halt_req, resume_req, step_req, dbg_pc_we, dbg_pc_wdata,
        input  pc, pc_plus, halted, step_done, upd_count, misalign_flag
    );

    modport slave (
        input  stall, reset_stages, redirect_valid, redirect_target,
               halt_req, resume_req, step_req, dbg_pc_we, dbg_pc_wdata,
        output pc, pc_plus, halted, step_done, upd_count, misalign_flag
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with stall/flush/redirect, debug run-control FSM and update counter; PC_ALIGN_CHECK_EN traps misaligned targets
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0008),
    parameter int              INC_BYTES    = 4,
    parameter int              CNT_W        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0004)
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q;
    logic             step_done_q, step_done_d;
    logic             misalign_q, misalign_d;
    logic             adv_en;
    logic             mis_rd;
    logic             mis_dbg;

`ifdef PC_ALIGN_CHECK_EN
    assign mis_rd  = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    assign mis_dbg = bus.dbg_pc_wdata[1:0] != 2'b00;
`else
    assign mis_rd  = 1'b0;
    assign mis_dbg = 1'b0;
`endif

    assign adv_en = ((state_q == RUN && !bus.halt_req) || state_q == STEP) && !bus.stall;

    // run-control transitions; a flush during STEP consumes the step
    always_comb begin
        state_d     = state_q;
        step_done_d = (state_q == STEP) && (bus.reset_stages || !bus.stall);
        case (state_q)
            RUN:     state_d = bus.halt_req ? HALTED : RUN;
            HALTED:  state_d = bus.step_req ? STEP : ((bus.resume_req && !bus.halt_req) ? RUN : HALTED);
            STEP:    state_d = step_done_d ? HALTED : STEP;
            default: state_d = RUN;
        endcase
    end

    // next PC and counter: flush > debug write while halted > advance
    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        if (bus.reset_stages) begin
            pc_d = RESET_VECTOR;
        end else if (state_q == HALTED && bus.dbg_pc_we) begin
            pc_d       = mis_dbg ? TRAP_VECTOR : bus.dbg_pc_wdata;
            misalign_d = mis_dbg;
        end else if (adv_en) begin
            pc_d       = bus.redirect_valid ? (mis_rd ? TRAP_VECTOR : bus.redirect_target)
                                            : pc_q + XLEN'(INC_BYTES);
            misalign_d = mis_rd;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_VECTOR;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            halted_q    <= (state_d == HALTED);
            step_done_q <= step_done_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_q + XLEN'(INC_BYTES);
    assign bus.halted        = halted_q;
    assign bus.step_done     = step_done_q;
    assign bus.upd_count     = cnt_q;
    assign bus.misalign_flag = misalign_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; honours PC_ALIGN_CHECK_EN when defined
module tb_pc_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32), .CNT_W(32)) bus();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        h;
        logic        sd;
        logic        mf;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc = 32'h8;
    logic [31:0] m_cnt = 0;
    int          m_st = 0;
    logic        m_h = 0, m_sd = 0, m_mf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic misal(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
        return v[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model();
        logic adv, nsd;
        int   ns;
        exp_t e;
        if (reset) begin
            m_pc = 32'h8; m_cnt = 0; m_st = 0; m_h = 0; m_sd = 0; m_mf = 0;
        end else begin
            adv = ((m_st == 0 && !bus.halt_req) || m_st == 2) && !bus.stall;
            nsd = (m_st == 2) && (bus.reset_stages || !bus.stall);
            ns  = m_st;
            if (m_st == 0 && bus.halt_req) ns = 1;
            if (m_st == 1) ns = bus.step_req ? 2 : ((bus.resume_req && !bus.halt_req) ? 0 : 1);
            if (m_st == 2 && nsd) ns = 1;
            m_mf = 0;
            if (bus.reset_stages) m_pc = 32'h8;
            else if (m_st == 1 && bus.dbg_pc_we) begin
                m_mf = misal(bus.dbg_pc_wdata);
                m_pc = m_mf ? 32'h4 : bus.dbg_pc_wdata;
            end else if (adv) begin
                if (bus.redirect_valid) begin
                    m_mf = misal(bus.redirect_target);
                    m_pc = m_mf ? 32'h4 : bus.redirect_target;
                end else m_pc = m_pc + 32'd4;
                m_cnt = m_cnt + 1;
            end
            m_st = ns; m_h = (ns == 1); m_sd = nsd;
        end
        e.pc = m_pc; e.cnt = m_cnt; e.h = m_h; e.sd = m_sd; e.mf = m_mf;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pc", bus.pc, e.pc);
            check("pc_plus", bus.pc_plus, e.pc + 32'd4);
            check("upd_count", bus.upd_count, e.cnt);
            check("halted", 32'(bus.halted), 32'(e.h));
            check("step_done", 32'(bus.step_done), 32'(e.sd));
            check("misalign_flag", 32'(bus.misalign_flag), 32'(e.mf));
        end
    endtask

    task automatic idle_in();
        bus.stall = 0; bus.reset_stages = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
        bus.halt_req = 0; bus.resume_req = 0; bus.step_req = 0; bus.dbg_pc_we = 0; bus.dbg_pc_wdata = 0;
    endtask

    initial begin
        logic [31:0] r;
        idle_in();
        reset = 1;
        tick();
        check("rst_pc", bus.pc, 32'h8);
        check("rst_cnt", bus.upd_count, 32'd0);
        reset = 0;
        repeat (4) tick();
        check("free_pc", bus.pc, 32'h18);
        check("free_cnt", bus.upd_count, 32'd4);
        bus.redirect_valid = 1; bus.redirect_target = 32'h100; bus.stall = 1;
        repeat (2) tick();
        check("stall_hold", bus.pc, 32'h18);
        bus.stall = 0;
        tick();
        check("redir_pc", bus.pc, 32'h100);
        check("redir_cnt", bus.upd_count, 32'd5);
        bus.redirect_target = 32'h20;
        tick();
        bus.halt_req = 1; bus.redirect_target = 32'h300;
        tick();
        check("halt_pc", bus.pc, 32'h20);
        check("halt_flag", 32'(bus.halted), 32'd1);
        bus.redirect_valid = 0; bus.dbg_pc_we = 1; bus.dbg_pc_wdata = 32'h40;
        tick();
        check("dbg_wr", bus.pc, 32'h40);
        bus.dbg_pc_we = 0; bus.step_req = 1; bus.stall = 1;
        tick();
        bus.step_req = 0;
        repeat (2) tick();
        check("step_wait", bus.pc, 32'h40);
        bus.stall = 0;
        tick();
        check("step_pc", bus.pc, 32'h44);
        check("step_done", 32'(bus.step_done), 32'd1);
        check("step_halted", 32'(bus.halted), 32'd1);
        tick();
        check("step_done_1cyc", 32'(bus.step_done), 32'd0);
        bus.resume_req = 1;
        tick();
        check("resume_ign", 32'(bus.halted), 32'd1);
        bus.halt_req = 0;
        tick();
        check("resume_run", 32'(bus.halted), 32'd0);
        bus.resume_req = 0;
        tick();
        check("resume_adv", bus.pc, 32'h48);
        bus.redirect_valid = 1; bus.redirect_target = 32'h80;
        tick();
        bus.redirect_valid = 0; bus.halt_req = 1;
        tick();
        bus.step_req = 1; bus.stall = 1;
        tick();
        bus.step_req = 0; bus.reset_stages = 1;
        tick();
        check("flush_pc", bus.pc, 32'h8);
        check("flush_sd", 32'(bus.step_done), 32'd1);
        check("flush_halt", 32'(bus.halted), 32'd1);
        bus.reset_stages = 0; bus.stall = 0; bus.halt_req = 0; bus.resume_req = 1;
        tick();
        bus.resume_req = 0; bus.dbg_pc_we = 1; bus.dbg_pc_wdata = 32'h200;
        tick();
        check("dbg_run_ign", bus.pc, 32'hC);
        bus.dbg_pc_we = 0; bus.redirect_valid = 1; bus.redirect_target = 32'h102;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("misal_pc", bus.pc, 32'h4);
        check("misal_flag", 32'(bus.misalign_flag), 32'd1);
`else
        check("misal_pc", bus.pc, 32'h102);
`endif
        bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 0;
        tick();
        check("wrap_pc", bus.pc, 32'h0);
        for (int i = 0; i < 300; i++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.reset_stages = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) bus.halt_req = ~bus.halt_req;
            bus.resume_req = ($urandom_range(0, 5) == 0);
            bus.step_req = ($urandom_range(0, 5) == 0);
            bus.dbg_pc_we = ($urandom_range(0, 5) == 0);
            bus.redirect_valid = ($urandom_range(0, 3) == 0);
            r = $urandom();
            bus.redirect_target = ($urandom_range(0, 3) == 0) ? r : {r[31:2], 2'b00};
            r = $urandom();
            bus.dbg_pc_wdata = ($urandom_range(0, 3) == 0) ? r : {r[31:2], 2'b00};
            tick();
        end
        idle_in();
        reset = 1;
        tick();
        check("rerst_cnt", bus.upd_count, 32'd0);
        check("rerst_pc", bus.pc, 32'h8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
